// File: rtl/sistema_pkg.sv
// Shared definitions for the binary-to-BCD display path: state encoding,
// digit count default and BCD constants.
package sistema_pkg;

  // Converter state; also exported on the debug port of conversor_bcd.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } estado_t;

  // Five digits, one per HEX display.
  localparam int DIGITS_DEF = 5;

  // 10^n as a 64-bit value, for elaboration-time limits.
  function automatic logic [63:0] pot10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

  // Largest value the default digit count can show (99999).
  localparam logic [63:0] BCD_MAX  = pot10(DIGITS_DEF) - 64'd1;
  // Saturation digit.
  localparam logic [3:0]  BCD_NOVE = 4'h9;

endpackage

// File: rtl/ajuste_bcd.sv
// Double-dabble correction cell: a BCD digit of 5 or more gets 3 added so
// that the following left shift carries correctly into the next digit.
module ajuste_bcd (
  input  logic [3:0] i_digito,
  output logic [3:0] o_digito
);

  // Add 3 when the digit would be 10 or more after the shift.
  always_comb begin
    o_digito = i_digito;
    if (i_digito >= 4'd5) begin
      o_digito = i_digito + 4'd3;
    end
  end

endmodule

// File: rtl/conversor_bcd.sv
// Sequential signed binary to BCD converter for the seven-segment stage.
// A request captures |valor|, its sign and an overflow flag, then WIDTH
// shift-and-add-3 steps build the digits. Results are registered and only
// change on the completion edge, which also raises done for one cycle.
//
// Handshake: start is honoured only while busy=0 (IDLE, which includes the
// done cycle); valor is sampled on that accepting edge only. busy stays high
// for exactly WIDTH cycles, and the cycle after the last shift carries
// done=1 with busy=0 and the new results. start while busy=1 is dropped.
module conversor_bcd
  import sistema_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      valor,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   digitos,
  output logic                  negativo,
  output logic                  overflow,
  output estado_t               estado_dbg
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  // The overflow compare is done on 64 bits, so WIDTH is limited to 64.
  localparam logic [63:0]   LP_MAX    = pot10(DIGITS) - 64'd1;
  localparam logic [CW-1:0] LP_ULTIMO = CW'(WIDTH - 1);

  estado_t          r_estado;
  logic [WIDTH-1:0] r_mag;
  logic [BW-1:0]    r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_neg;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;
  logic [BW-1:0]    r_digitos;
  logic             r_negativo;
  logic             r_overflow;

  logic [WIDTH-1:0] w_mag;
  logic [63:0]      w_mag64;
  logic             w_ovf;
  logic [BW-1:0]    w_acc_adj;
  logic [BW-1:0]    w_acc_next;
  logic [BW-1:0]    w_sat;
  logic             w_ultimo;

  // Magnitude of the incoming value; the most negative input maps to
  // 2^(WIDTH-1), which still fits as an unsigned WIDTH-bit number.
  assign w_mag   = valor[WIDTH-1] ? (~valor + WIDTH'(1)) : valor;
  assign w_mag64 = 64'(w_mag);
  assign w_ovf   = (w_mag64 > LP_MAX);

  // Per-digit add-3 correction on the current accumulator.
  for (genvar g = 0; g < DIGITS; g++) begin : g_ajuste
    ajuste_bcd u_ajuste (
      .i_digito (r_acc[4*g +: 4]),
      .o_digito (w_acc_adj[4*g +: 4])
    );
  end

  // Accumulator after this step's shift; the top bit falls off.
  assign w_acc_next = {w_acc_adj[BW-2:0], r_mag[WIDTH-1]};
  assign w_sat      = {DIGITS{BCD_NOVE}};
  assign w_ultimo   = (r_cnt == LP_ULTIMO);

  // Converter FSM with all outputs registered; reset wins over everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado   <= IDLE;
      r_mag      <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_neg      <= 1'b0;
      r_ovf      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_digitos  <= '0;
      r_negativo <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_estado)
        IDLE: begin
          if (start) begin
            r_mag    <= w_mag;
            r_neg    <= valor[WIDTH-1];
            r_ovf    <= w_ovf;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_estado <= SHIFT;
          end
        end
        SHIFT: begin
          r_acc <= w_acc_next;
          r_mag <= {r_mag[WIDTH-2:0], 1'b0};
          r_cnt <= r_cnt + CW'(1);
          if (w_ultimo) begin
            r_digitos  <= r_ovf ? w_sat : w_acc_next;
            r_negativo <= r_neg;
            r_overflow <= r_ovf;
            r_done     <= 1'b1;
            r_busy     <= 1'b0;
            r_estado   <= IDLE;
          end
        end
        default: begin
          r_estado <= IDLE;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign digitos    = r_digitos;
  assign negativo   = r_negativo;
  assign overflow   = r_overflow;
  assign estado_dbg = r_estado;

endmodule
